// File: rtl/fu_pkg.sv
// fu_pkg: shared types and sizing helpers for the programmable function unit.
// FSM state encoding, table depth / configuration length helpers, clog2.
package fu_pkg;

    typedef logic [1:0] fu_state_t;

    localparam fu_state_t ST_EMPTY = 2'd0;  // no valid table yet
    localparam fu_state_t ST_LOAD  = 2'd1;  // shifting bits into the shadow table
    localparam fu_state_t ST_RUN   = 2'd2;  // active table valid, idle config port

    // Number of minterms selectable by an in_w-bit input.
    function automatic int fu_depth(input int in_w);
        return 1 << in_w;
    endfunction

    // Total configuration bits across all channels.
    function automatic int fu_cfg_len(input int in_w, input int channels);
        return channels * (1 << in_w);
    endfunction

    // Ceiling log2, never less than 1 so counters always have a bit.
    function automatic int fu_clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        if (width == 0) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/fu_decoder.sv
// fu_decoder: combinational IN_W -> 2^IN_W one-hot minterm decoder.
module fu_decoder
    import fu_pkg::*;
#(
    parameter int IN_W = 4
) (
    input  logic [IN_W-1:0]           sel,
    output logic [fu_depth(IN_W)-1:0] onehot
);

    // Raise exactly the bit addressed by sel.
    always_comb begin
        // NOTE: default assignment first so every path drives onehot; no latch.
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/prog_fu_lut.sv
// prog_fu_lut: programmable multi-channel truth-table function unit.
// Each channel holds a 2^IN_W-entry table, reloaded serially through a shadow
// copy so partially loaded tables are never used for evaluation. Output is
// registered with one cycle latency and tagged by out_valid.
// Optional: define FU_DECODE_OUT_EN to add the registered dec_onehot port.
module prog_fu_lut
    import fu_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic                      cfg_valid,
    input  logic                      cfg_bit,
    output logic                      cfg_ready,
    output logic                      cfg_done,
    input  logic                      in_valid,
    input  logic [IN_W-1:0]           in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       out_data
`ifdef FU_DECODE_OUT_EN
    ,
    output logic [fu_depth(IN_W)-1:0] dec_onehot
`endif
);

    localparam int DEPTH   = fu_depth(IN_W);
    localparam int CFG_LEN = fu_cfg_len(IN_W, CHANNELS);
    localparam int CNT_W   = fu_clog2(CFG_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_LEN - 1);

    // Tables are flat: bit c*DEPTH + m is channel c, minterm m, which matches
    // the serial load order so the load counter indexes the shadow directly.
    fu_state_t             state;
    fu_state_t             state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [CFG_LEN-1:0]    shadow;
    logic [CFG_LEN-1:0]    shadow_nxt;
    logic [CFG_LEN-1:0]    active;
    logic                  table_valid;
    logic                  last_accept;
    logic                  in_accept;
    logic [DEPTH-1:0]      onehot;
    logic [CHANNELS-1:0]   eval;

    assign cfg_ready = (state == ST_LOAD);
    assign in_ready  = table_valid;
    assign in_accept = in_valid & in_ready;

    // cfg_start wins over cfg_valid, so a restart cycle never loads a bit.
    assign last_accept = (state == ST_LOAD) && !cfg_start && cfg_valid && (cnt == CNT_LAST);

    fu_decoder #(
        .IN_W (IN_W)
    ) u_decoder (
        .sel    (in_data),
        .onehot (onehot)
    );

    // Per-channel lookup: OR of the decoded minterm against the active table.
    always_comb begin
        eval = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            eval[c] = |(onehot & active[c*DEPTH +: DEPTH]);
        end
    end

    // Load FSM next-state, counter and shadow write.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        case (state)
            ST_EMPTY: begin
                if (cfg_start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    cnt_nxt = '0;
                end else if (cfg_valid) begin
                    shadow_nxt[cnt] = cfg_bit;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (cfg_start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Load state, shadow table and commit of the shadow into the active table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the tables are reset because a reset must invalidate any
            // previously loaded function; they are flops, not a RAM.
            state       <= ST_EMPTY;
            cnt         <= '0;
            shadow      <= '0;
            active      <= '0;
            table_valid <= 1'b0;
            cfg_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shadow   <= shadow_nxt;
            cfg_done <= last_accept;
            if (last_accept) begin
                active      <= shadow_nxt;
                table_valid <= 1'b1;
            end
        end
    end

    // Registered evaluation result; data holds when no input is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_accept;
            if (in_accept) begin
                out_data <= eval;
            end
        end
    end

`ifdef FU_DECODE_OUT_EN
    // Decoded minterm registered alongside out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_onehot <= '0;
        end else if (in_accept) begin
            dec_onehot <= onehot;
        end
    end
`endif

endmodule

// File: tb/tb_prog_fu_lut.sv
// tb_prog_fu_lut: directed self-checking bench for prog_fu_lut (IN_W=4, CHANNELS=2).
// Works with or without FU_DECODE_OUT_EN defined.
module tb_prog_fu_lut;

    logic       clk;
    logic       rst_n;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_ready;
    logic       cfg_done;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;
`ifdef FU_DECODE_OUT_EN
    logic [15:0] dec_onehot;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] stream_in  [7] = '{4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b1011, 4'b1111};
    logic [1:0] stream_exp [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};

    prog_fu_lut #(
        .IN_W     (4),
        .CHANNELS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data)
`ifdef FU_DECODE_OUT_EN
        ,
        .dec_onehot (dec_onehot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a reload (cfg_start with a stray cfg_valid bit that must be ignored),
    // then shift nbits of {ch1, ch0} LSB first. Optionally checks the streamed
    // output on every cycle against the old-table value.
    task automatic load_tables(input logic [15:0] ch0, input logic [15:0] ch1,
                               input int nbits, input bit stream_chk,
                               input logic [1:0] stream_val);
        logic [31:0] img;
        img       = {ch1, ch0};
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("cfg_ready_in_load", cfg_ready, 1);
        if (stream_chk) check("stream_old_start", out_data, stream_val);
        for (int k = 0; k < nbits; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = img[k];
            tick();
            if (stream_chk) check("stream_old_table", out_data, stream_val);
            if (k < 31) check("no_early_done", cfg_done, 0);
        end
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        #1 rst_n  = 1'b0;
        #2;

        // Reset values
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_cfg_done",  cfg_done,  0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
`ifdef FU_DECODE_OUT_EN
        check("rst_dec_onehot", dec_onehot, 0);
`endif
        tick();
        #2 rst_n = 1'b1;

        // Inputs are refused before any table is loaded; cfg_valid ignored in EMPTY
        in_valid  = 1'b1;
        in_data   = 4'b0000;
        cfg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("empty_in_ready",  in_ready,  0);
            check("empty_out_valid", out_valid, 0);
            check("empty_cfg_ready", cfg_ready, 0);
        end
        in_valid  = 1'b0;
        cfg_valid = 1'b0;

        // First load: ch0=0155, ch1=8000
        load_tables(16'h0155, 16'h8000, 32, 1'b0, 2'b00);
        check("load1_done",     cfg_done, 1);
        check("load1_in_ready", in_ready, 1);
        tick();
        check("load1_done_pulse", cfg_done,  0);
        check("load1_cfg_ready",  cfg_ready, 0);

        // Back-to-back evaluation
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = stream_in[i];
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data",  out_data,  stream_exp[i]);
`ifdef FU_DECODE_OUT_EN
            check("stream_onehot", dec_onehot, 32'd1 << stream_in[i]);
`endif
        end
        in_valid = 1'b0;
        tick();
        check("idle_valid", out_valid, 0);
        check("idle_hold",  out_data,  2'b10);

        // Reload while streaming 1111: old result through commit, new after
        in_valid = 1'b1;
        in_data  = 4'b1111;
        tick();
        check("pre_reload_data", out_data, 2'b10);
        load_tables(16'hFFFF, 16'h0000, 32, 1'b1, 2'b10);
        check("load2_done", cfg_done, 1);
        tick();
        check("load2_new_valid", out_valid, 1);
        check("load2_new_data",  out_data,  2'b01);
        check("load2_done_pulse", cfg_done, 0);
        in_valid = 1'b0;

        // Aborted partial load, then full reload with ch0=0001
        load_tables(16'hFFFF, 16'hFFFF, 10, 1'b0, 2'b00);
        check("partial_no_done",   cfg_done,  0);
        check("partial_cfg_ready", cfg_ready, 1);
        load_tables(16'h0001, 16'h0000, 32, 1'b0, 2'b00);
        check("load3_done", cfg_done, 1);
        in_valid = 1'b1;
        in_data  = 4'b0000;
        tick();
        check("load3_m0",  out_data, 2'b01);
        in_data  = 4'b0001;
        tick();
        check("load3_m1",  out_data, 2'b00);
        in_data  = 4'b1111;
        tick();
        check("load3_m15", out_data, 2'b00);

        // Asynchronous reset in the middle of a load
        in_data = 4'b0000;
        tick();
        check("pre_rst_data", out_data, 2'b01);
        load_tables(16'hAAAA, 16'h5555, 5, 1'b1, 2'b01);
        #3 rst_n = 1'b0;
        #1;
        check("arst_cfg_ready", cfg_ready, 0);
        check("arst_cfg_done",  cfg_done,  0);
        check("arst_in_ready",  in_ready,  0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data",  out_data,  0);
`ifdef FU_DECODE_OUT_EN
        check("arst_dec_onehot", dec_onehot, 0);
`endif
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_in_ready",  in_ready,  0);
            check("post_rst_out_valid", out_valid, 0);
            check("post_rst_cfg_ready", cfg_ready, 0);
        end

        // Full load after reset brings the unit back
        load_tables(16'h0000, 16'h0001, 32, 1'b0, 2'b00);
        check("load4_done",      cfg_done,  1);
        check("load4_in_ready",  in_ready,  1);
        check("load4_out_valid", out_valid, 0);
        tick();
        check("load4_valid", out_valid, 1);
        check("load4_data",  out_data,  2'b10);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
